mod_inverse_engine: RTL and testbench

//  Parametrised modular-inverse engine: computes inv = num^-1 mod modulus, or flags error if gcd(num,modulus)!=1.

---
 rtl/mod_inverse_engine.sv | 225 ++++++++++++++++++++++
 tb/tb_mod_inverse_engine.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mod_inverse_engine.sv
// Bit-serial shift-subtract extended-Euclid modular inverse: inverse = num^-1 mod modulus.
// Optional gcd_out port is enabled by defining MODINV_GCD_OUT_EN.
module mod_inverse_engine #(
    parameter int WIDTH = 512,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic             start,
    output logic             ready,
    input  logic [WIDTH-1:0] num,
    input  logic [WIDTH-1:0] modulus,
    output logic [WIDTH-1:0] inverse,
    output logic             done,
    output logic             error
`ifdef MODINV_GCD_OUT_EN
    ,
    output logic [WIDTH-1:0] gcd_out
`endif
);

    typedef logic signed [WIDTH+1:0] sword_t;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CHECK,
        S_RED_AL,
        S_RED_SUB,
        S_DIV_AL,
        S_DIV_SUB,
        S_SWAP,
        S_FIX,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic [WIDTH-1:0]   r0_q, r0_d;
    logic [WIDTH-1:0]   r1_q, r1_d;
    logic [WIDTH:0]     rs_q, rs_d;
    sword_t             t0_q, t0_d;
    sword_t             t1_q, t1_d;
    sword_t             ts_q, ts_d;
    logic [CNT_W-1:0]   k_q, k_d;
    logic [WIDTH-1:0]   inv_q, inv_d;
    logic               err_q, err_d;
`ifdef MODINV_GCD_OUT_EN
    logic [WIDTH-1:0]   gcd_q, gcd_d;
`endif

    logic [WIDTH+1:0]   rs_dbl;
    logic               rs_le_r0;
    logic               rs_le_r1;
    logic [WIDTH-1:0]   r1_sub;
    logic [WIDTH-1:0]   inv_fix;

    always_comb begin
        rs_dbl   = {rs_q, 1'b0};
        rs_le_r0 = (rs_q <= {1'b0, r0_q});
        rs_le_r1 = (rs_q <= {1'b0, r1_q});
        r1_sub   = rs_le_r1 ? (r1_q - rs_q[WIDTH-1:0]) : r1_q;
        // Low WIDTH bits of t0+m equal (t0+m) mod 2^WIDTH, so the sign fix works on the truncated value
        inv_fix  = t0_q[WIDTH+1] ? (t0_q[WIDTH-1:0] + m_q) : t0_q[WIDTH-1:0];
    end

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        r0_d    = r0_q;
        r1_d    = r1_q;
        rs_d    = rs_q;
        t0_d    = t0_q;
        t1_d    = t1_q;
        ts_d    = ts_q;
        k_d     = k_q;
        inv_d   = inv_q;
        err_d   = err_q;
`ifdef MODINV_GCD_OUT_EN
        gcd_d   = gcd_q;
`endif
        ready   = (state_q == S_IDLE);
        done    = (state_q == S_DONE);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    m_d     = modulus;
                    r1_d    = num;
                    err_d   = 1'b0;
                    inv_d   = '0;
`ifdef MODINV_GCD_OUT_EN
                    gcd_d   = '0;
`endif
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (m_q < WIDTH'(2)) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    r0_d    = m_q;
                    t0_d    = '0;
                    t1_d    = sword_t'(1);
                    rs_d    = {1'b0, m_q};
                    k_d     = '0;
                    state_d = S_RED_AL;
                end
            end
            // Reduction divides r1 by the modulus held in r0, the reverse of the Euclid steps
            S_RED_AL: begin
                if (rs_dbl <= {2'b00, r1_q}) begin
                    rs_d = rs_dbl[WIDTH:0];
                    k_d  = k_q + CNT_W'(1);
                end else begin
                    state_d = S_RED_SUB;
                end
            end
            S_RED_SUB: begin
                r1_d = r1_sub;
                rs_d = rs_q >> 1;
                k_d  = k_q - CNT_W'(1);
                if (k_q == '0) begin
                    rs_d    = {1'b0, r1_sub};
                    ts_d    = t1_q;
                    k_d     = '0;
                    state_d = S_DIV_AL;
                end
            end
            S_DIV_AL: begin
                if (r1_q == '0) begin
                    state_d = S_FIX;
                end else if (rs_dbl <= {2'b00, r0_q}) begin
                    rs_d = rs_dbl[WIDTH:0];
                    ts_d = ts_q <<< 1;
                    k_d  = k_q + CNT_W'(1);
                end else begin
                    state_d = S_DIV_SUB;
                end
            end
            S_DIV_SUB: begin
                if (rs_le_r0) begin
                    r0_d = r0_q - rs_q[WIDTH-1:0];
                    t0_d = t0_q - ts_q;
                end
                rs_d = rs_q >> 1;
                ts_d = ts_q >>> 1;
                k_d  = k_q - CNT_W'(1);
                if (k_q == '0) begin
                    state_d = S_SWAP;
                end
            end
            // The aligner is preloaded here so DIV_AL can start shifting on its first cycle
            S_SWAP: begin
                r0_d    = r1_q;
                r1_d    = r0_q;
                t0_d    = t1_q;
                t1_d    = t0_q;
                rs_d    = {1'b0, r0_q};
                ts_d    = t0_q;
                k_d     = '0;
                state_d = S_DIV_AL;
            end
            S_FIX: begin
`ifdef MODINV_GCD_OUT_EN
                gcd_d = r0_q;
`endif
                if (r0_q != WIDTH'(1)) begin
                    err_d = 1'b1;
                    inv_d = '0;
                end else begin
                    inv_d = inv_fix;
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q <= S_IDLE;
            m_q     <= '0;
            r0_q    <= '0;
            r1_q    <= '0;
            rs_q    <= '0;
            t0_q    <= '0;
            t1_q    <= '0;
            ts_q    <= '0;
            k_q     <= '0;
            inv_q   <= '0;
            err_q   <= 1'b0;
`ifdef MODINV_GCD_OUT_EN
            gcd_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            r0_q    <= r0_d;
            r1_q    <= r1_d;
            rs_q    <= rs_d;
            t0_q    <= t0_d;
            t1_q    <= t1_d;
            ts_q    <= ts_d;
            k_q     <= k_d;
            inv_q   <= inv_d;
            err_q   <= err_d;
`ifdef MODINV_GCD_OUT_EN
            gcd_q   <= gcd_d;
`endif
        end
    end

    assign inverse = inv_q;
    assign error   = err_q;
`ifdef MODINV_GCD_OUT_EN
    assign gcd_out = gcd_q;
`endif

endmodule

// File: tb/tb_mod_inverse_engine.sv
// Directed-vector and random checks for mod_inverse_engine at WIDTH=512.
module tb_mod_inverse_engine;

    localparam int W      = 512;
    localparam int MAXLAT = 8 * W + 16;

    typedef logic [W-1:0] word_t;
    typedef struct {
        word_t num;
        word_t m;
        logic  err;
        word_t inv;
        word_t gcd;
    } vec_t;

    logic  aclk = 1'b0;
    logic  areset = 1'b1;
    logic  start = 1'b0;
    logic  ready;
    word_t num = '0;
    word_t modulus = '0;
    word_t inverse;
    logic  done;
    logic  error;
`ifdef MODINV_GCD_OUT_EN
    word_t gcd_out;
`endif

    int checks = 0;
    int failures = 0;

    mod_inverse_engine #(.WIDTH(W)) dut (
        .aclk    (aclk),
        .areset  (areset),
        .start   (start),
        .ready   (ready),
        .num     (num),
        .modulus (modulus),
        .inverse (inverse),
        .done    (done),
        .error   (error)
`ifdef MODINV_GCD_OUT_EN
        ,
        .gcd_out (gcd_out)
`endif
    );

    always #5 aclk = ~aclk;

    task automatic check(input string name, input word_t act, input word_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input word_t n, input word_t m, input logic e,
                                input word_t i, input word_t g);
        vec_t v;
        v.num = n; v.m = m; v.err = e; v.inv = i; v.gcd = g;
        return v;
    endfunction

    function automatic word_t ref_gcd(input word_t a, input word_t b);
        word_t x = a;
        word_t y = b;
        word_t t;
        while (y != '0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Called #1 after a posedge with the engine idle; latency counts edges from the accepting edge.
    task automatic run(input word_t n, input word_t m, output word_t inv, output logic err,
                       output word_t g, output int lat, output logic busy_ready,
                       output logic timeout);
        start = 1'b1;
        num = n;
        modulus = m;
        lat = 0;
        busy_ready = 1'b0;
        timeout = 1'b1;
        for (int c = 1; c <= MAXLAT + 8; c++) begin
            @(posedge aclk); #1;
            if (c == 1) start = 1'b0;
            if (done) begin
                lat = c;
                timeout = 1'b0;
                break;
            end
            if (ready) busy_ready = 1'b1;
        end
        inv = inverse;
        err = error;
`ifdef MODINV_GCD_OUT_EN
        g = gcd_out;
`else
        g = '0;
`endif
    endtask

    vec_t  vecs[15];
    word_t one;
    word_t r_inv, r_g, rn, rm, eg;
    logic  r_err, r_busy, r_to;
    int    r_lat;
    logic  seen;

    initial begin
        one = word_t'(1);
        vecs[0]  = mk(word_t'(65537), word_t'(3120), 1'b0, word_t'(2753), one);
        vecs[1]  = mk(word_t'(3),  word_t'(7),  1'b0, word_t'(5), one);
        vecs[2]  = mk(word_t'(10), word_t'(7),  1'b0, word_t'(5), one);
        vecs[3]  = mk(word_t'(3),  word_t'(8),  1'b0, word_t'(3), one);
        vecs[4]  = mk(word_t'(6),  word_t'(9),  1'b1, '0, word_t'(3));
        vecs[5]  = mk(word_t'(2), (one << 127) - one, 1'b0, one << 126, one);
        vecs[6]  = mk(word_t'(0),  word_t'(5),  1'b1, '0, word_t'(5));
        vecs[7]  = mk(word_t'(14), word_t'(7),  1'b1, '0, word_t'(7));
        vecs[8]  = mk(word_t'(1),  word_t'(2),  1'b0, one, one);
        vecs[9]  = mk(word_t'(5),  word_t'(2),  1'b0, one, one);
        vecs[10] = mk(word_t'(7),  word_t'(3120), 1'b0, word_t'(1783), one);
        vecs[11] = mk(word_t'(7),  word_t'(8),  1'b0, word_t'(7), one);
        vecs[12] = mk(word_t'(2),  '1, 1'b0, one << 511, one);
        vecs[13] = mk(word_t'(8),  word_t'(8),  1'b1, '0, word_t'(8));
        vecs[14] = mk(word_t'(21), word_t'(9),  1'b1, '0, word_t'(3));

        repeat (3) @(posedge aclk);
        #1 areset = 1'b0;
        check("rst_ready", word_t'(ready), one);
        check("rst_done", word_t'(done), '0);
        check("rst_error", word_t'(error), '0);
        check("rst_inverse", inverse, '0);
`ifdef MODINV_GCD_OUT_EN
        check("rst_gcd", gcd_out, '0);
`endif

        foreach (vecs[i]) begin
            run(vecs[i].num, vecs[i].m, r_inv, r_err, r_g, r_lat, r_busy, r_to);
            check($sformatf("vec%0d_timeout", i), word_t'(r_to), '0);
            check($sformatf("vec%0d_inv", i), r_inv, vecs[i].inv);
            check($sformatf("vec%0d_err", i), word_t'(r_err), word_t'(vecs[i].err));
`ifdef MODINV_GCD_OUT_EN
            check($sformatf("vec%0d_gcd", i), r_g, vecs[i].gcd);
`endif
            check($sformatf("vec%0d_lat_bound", i), word_t'(r_lat <= MAXLAT), one);
            check($sformatf("vec%0d_ready_busy", i), word_t'(r_busy), '0);
            @(posedge aclk); #1;
            check($sformatf("vec%0d_done_pulse", i), word_t'(done), '0);
            check($sformatf("vec%0d_ready_after", i), word_t'(ready), one);
        end

        // Degenerate moduli finish two cycles after start
        run(word_t'(5), word_t'(1), r_inv, r_err, r_g, r_lat, r_busy, r_to);
        check("m1_latency", word_t'(r_lat), word_t'(2));
        check("m1_err", word_t'(r_err), one);
        check("m1_inv", r_inv, '0);
`ifdef MODINV_GCD_OUT_EN
        check("m1_gcd", r_g, '0);
`endif
        @(posedge aclk); #1;
        run(word_t'(9), word_t'(0), r_inv, r_err, r_g, r_lat, r_busy, r_to);
        check("m0_latency", word_t'(r_lat), word_t'(2));
        check("m0_err", word_t'(r_err), one);
        @(posedge aclk); #1;

        // start held high across the whole operation, including the done cycle
        start = 1'b1; num = word_t'(65537); modulus = word_t'(3120);
        @(posedge aclk); #1;
        num = word_t'(3); modulus = word_t'(7);
        seen = 1'b0;
        for (int c = 0; c < MAXLAT + 8; c++) begin
            @(posedge aclk); #1;
            if (done) begin seen = 1'b1; break; end
        end
        check("hold_done_seen", word_t'(seen), one);
        check("hold_inv", inverse, word_t'(2753));
        @(posedge aclk); #1;
        check("hold_ready_after_done", word_t'(ready), one);
        start = 1'b0;
        @(posedge aclk); #1;
        check("hold_not_accepted", word_t'(ready), one);
        check("hold_inv_kept", inverse, word_t'(2753));

        // Abort by reset mid-operation
        start = 1'b1; num = word_t'(65537); modulus = word_t'(3120);
        @(posedge aclk); #1;
        start = 1'b0;
        repeat (10) @(posedge aclk);
        #1 areset = 1'b1;
        @(posedge aclk); #1;
        areset = 1'b0;
        check("abort_ready", word_t'(ready), one);
        check("abort_error", word_t'(error), '0);
        seen = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(posedge aclk); #1;
            if (done) seen = 1'b1;
        end
        check("abort_no_done", word_t'(seen), '0);
        run(word_t'(3), word_t'(7), r_inv, r_err, r_g, r_lat, r_busy, r_to);
        check("post_abort_inv", r_inv, word_t'(5));
        check("post_abort_err", word_t'(r_err), '0);
        @(posedge aclk); #1;

        // Random 64-bit operands checked against gcd and the defining congruence
        for (int i = 0; i < 60; i++) begin
            rm = word_t'({$urandom, $urandom});
            rn = word_t'({$urandom, $urandom});
            if (i % 4 == 0) begin
                rm[0] = 1'b0;
                rn[0] = 1'b0;
            end
            if (rm < word_t'(2)) rm = word_t'(2);
            eg = ref_gcd(rm, rn % rm);
            run(rn, rm, r_inv, r_err, r_g, r_lat, r_busy, r_to);
            check($sformatf("rnd%0d_timeout", i), word_t'(r_to), '0);
            check($sformatf("rnd%0d_err", i), word_t'(r_err), word_t'(eg != one));
            if (eg == one)
                check($sformatf("rnd%0d_congruence", i),
                      word_t'((r_inv < rm) && (((r_inv * rn) % rm) == one)), one);
            else
                check($sformatf("rnd%0d_inv_zero", i), r_inv, '0);
`ifdef MODINV_GCD_OUT_EN
            check($sformatf("rnd%0d_gcd", i), r_g, eg);
`endif
            @(posedge aclk); #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
